// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes and burst FSM states.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } usr_state_e;

endpackage

// File: rtl/usr_shift_core.sv
// Combinational next-value function of the shift register for one operation step.
module usr_shift_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q_next
);

  // operation decode; unknown codes fall back to hold
  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
      MODE_LOAD: q_next = din;
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLR:  q_next = {WIDTH{1'b0}};
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg_n.sv
// N-bit universal shift register with a counted burst engine.
// Optional USR_STATUS_EN adds registered zero_flag and parity outputs.
module universal_shift_reg_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
`ifdef USR_STATUS_EN
  ,
  output logic             zero_flag,
  output logic             parity
`endif
);

  usr_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       mode_r, mode_s, op_mode_s;
  logic [WIDTH-1:0] q_r, q_s, core_q_s;
  logic             busy_r, busy_s, done_r, done_s;

  // a running burst replays its captured operation; otherwise the live mode drives the core
  always_comb begin
    if (state_r == ST_BUSY) begin
      op_mode_s = mode_r;
    end else begin
      op_mode_s = mode;
    end
  end

  usr_shift_core #(.WIDTH(WIDTH)) u_core (
    .q      (q_r),
    .mode   (op_mode_s),
    .din    (din),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .q_next (core_q_s)
  );

  // state register together with the burst bookkeeping and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      mode_r  <= MODE_HOLD;
      q_r     <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
      q_r     <= q_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // next-state: a start edge only captures the request, it never touches q
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    mode_s  = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (en && start) begin
          mode_s = mode;
          cnt_s  = count;
          if (count != {CNT_W{1'b0}}) begin
            state_s = ST_BUSY;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (en) begin
          cnt_s = cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_BUSY;
          end
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // outputs: next q, busy follows the next state, done marks the final step
  always_comb begin
    q_s    = q_r;
    done_s = 1'b0;
    busy_s = (state_s == ST_BUSY);
    case (state_r)
      ST_IDLE: begin
        if (en && !start) begin
          q_s = core_q_s;
        end else if (en && start && (count == {CNT_W{1'b0}})) begin
          done_s = 1'b1;
        end else begin
          q_s = q_r;
        end
      end
      ST_BUSY: begin
        if (en) begin
          q_s    = core_q_s;
          done_s = (cnt_r == CNT_W'(1));
        end else begin
          q_s = q_r;
        end
      end
      default: q_s = q_r;
    endcase
  end

  assign q      = q_r;
  assign sout_r = q_r[0];
  assign sout_l = q_r[WIDTH-1];
  assign busy   = busy_r;
  assign done   = done_r;

`ifdef USR_STATUS_EN
  logic zero_r, parity_r;

  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // status flags are computed from the next q so they line up with q itself
  always_ff @(posedge clk) begin
    if (!rst) begin
      zero_r   <= 1'b1;
      parity_r <= 1'b0;
    end else begin
      zero_r   <= (q_s == {WIDTH{1'b0}});
      parity_r <= parity_of(q_s);
    end
  end

  assign zero_flag = zero_r;
  assign parity    = parity_r;
`endif

endmodule
